tx_protocol_mux: RTL
====================

# tx_protocol_mux

Parametrised successor to the three-source transmit protocol block. It arbitrates among NUM_CH source-interface (SI) producers, such as trigger status and sampled channels. Once a source is granted, it owns the link until it signals eof. Each DATA_WIDTH word is serialised into TX_WIDTH beats toward the tx link layer (UART/FT245 front end) using a proper rdy/ack handshake on both sides.

## Interface
Parameters:
- NUM_CH, 3: number of SI sources; index 0 is highest fixed priority.
- DATA_WIDTH, 16: source word width.
- TX_WIDTH, 8: output beat width.
- Derived: NBEATS = ceil(DATA_WIDTH/TX_WIDTH); BEAT_BITS = max(1, clog2(NBEATS)); SEL_BITS = max(1, clog2(NUM_CH)).

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- src_data, in, NUM_CH*DATA_WIDTH: flattened source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_rdy, in, NUM_CH: source i presents a valid word.
- src_eof, in, NUM_CH: source i has no more data; valid together with, or without, rdy.
- src_ack, out, NUM_CH: one-cycle pulse telling source i its word was consumed.
- tx_data, out, TX_WIDTH: current beat.
- tx_rdy, out, 1: tx_data is valid.
- tx_ack, in, 1: link accepts the beat; a transfer occurs when tx_rdy & tx_ack.
- busy, out, 1: a source is locked (any state except IDLE).
- cur_src, out, SEL_BITS: index of the locked source; holds its last value in IDLE.

## Operation
States: IDLE, SEND, NEXT.
- IDLE:
  - If any src_rdy is set, grant the winner (see Configuration).
  - Latch its word into the shift register and latch last = src_eof[winner].
  - Set cur_src, beat counter = 0, go to SEND.
  - src_eof without rdy is ignored in IDLE.
- SEND:
  - tx_rdy = 1. tx_data = beat `cnt` of the word, least-significant chunk first.
  - The final beat is zero-padded in its high bits when DATA_WIDTH % TX_WIDTH ≠ 0.
  - On tx_ack: if cnt < NBEATS-1, then cnt++ and shift. Otherwise, go to IDLE if last = 1, else go to NEXT.
  - tx_rdy holds and tx_data is stable while tx_ack = 0. There is no timeout.
- NEXT, looking only at the locked source s:
  - rdy = 1: capture the word, last = src_eof[s], go to SEND.
  - rdy = 0 and eof = 1: go to IDLE.
  - Neither: stay in NEXT. Other sources cannot preempt.
- src_ack[s]:
  - Registered, high for exactly the cycle after each capture.
  - At most one bit is set at a time.
  - The source must update rdy/data on the edge where it sees ack.
- Inputs of non-locked sources are don't-care while busy.

## Timing
- Reset (rst = 0, asynchronous):
  - State IDLE; tx_rdy = 0, tx_data = 0, src_ack = 0, busy = 0, cur_src = 0, RR pointer = 0.
  - Any partial word is discarded. Operation resumes on the first edge after rst rises.
- Capture edge t:
  - src_ack and tx_rdy are high in cycle t+1.
  - The first beat cannot transfer before cycle t+1.
- NEXT lasts at least 1 cycle, so rdy is sampled after the source has reacted to ack.
- Sustained throughput with tx_ack tied high: one word per NBEATS+1 cycles.
- Minimum IDLE-to-IDLE time for a single last word: NBEATS+1 cycles.
- Simultaneous requests in IDLE are resolved in the same cycle; exactly one source is granted.
- NUM_CH = 1 and NBEATS = 1 are legal. NBEATS = 1 means no shifting and cnt is always 0.

## Configuration
- TX_PROTOCOL_MUX_RR_EN defined:
  - Round-robin arbitration. The search starts at (previous grant + 1) mod NUM_CH.
  - The pointer updates on each IDLE grant.
- Not defined:
  - Fixed priority; the lowest index wins.
  - No pointer register is synthesised.

## Test plan
- Single word, NUM_CH=3, DATA_WIDTH=16, TX_WIDTH=8: src1 presents 0xA55A with eof=1 and tx_ack=1 → tx beats 0x5A then 0xA5; src_ack[1] pulses once; busy returns to 0 after the second beat.
- Burst with backpressure: src2 sends 0x1234, 0x5678 (eof on the second) while tx_ack toggles 1,0 → beats 34,12,78,56 in order; each beat is held stable while tx_ack=0; two src_ack[2] pulses.
- Contention: src0 and src2 assert rdy together from IDLE → without the macro, src0 is granted twice in succession; with TX_PROTOCOL_MUX_RR_EN, grants go 0, 2, 0, 2.
- Eof without data: src0 locked in NEXT, rdy=0, eof=1 → IDLE next edge, no beats, no ack; src1's pending request is granted the following cycle.
- Padding: DATA_WIDTH=12, TX_WIDTH=8, word 0xABC → beats 0xBC then 0x0A.
- Reset mid-burst: assert rst low between beats 1 and 2 → tx_rdy, src_ack and busy drop to 0 immediately (asynchronously); after release, a fresh request sends from beat 0.

Source files
------------

// File: rtl/tx_protocol_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_protocol_mux_if
// Purpose  : Source-side and link-side signal bundle for tx_protocol_mux.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_protocol_mux_if #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int TX_WIDTH   = 8
) ();
    localparam int SEL_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_WIDTH-1:0] src_data;
    logic [NUM_CH-1:0]            src_rdy;
    logic [NUM_CH-1:0]            src_eof;
    logic [NUM_CH-1:0]            src_ack;
    logic [TX_WIDTH-1:0]          tx_data;
    logic                         tx_rdy;
    logic                         tx_ack;
    logic                         busy;
    logic [SEL_BITS-1:0]          cur_src;

    // Producer/link side.
    modport master (
        output src_data, src_rdy, src_eof, tx_ack,
        input  src_ack, tx_data, tx_rdy, busy, cur_src
    );

    // Multiplexer side.
    modport slave (
        input  src_data, src_rdy, src_eof, tx_ack,
        output src_ack, tx_data, tx_rdy, busy, cur_src
    );
endinterface
`default_nettype wire

// File: rtl/tx_protocol_mux.sv
`default_nettype none
// ============================================================================
// Module   : tx_protocol_mux
// Purpose  : Locks one of NUM_CH sources until eof and serialises its words
//            into TX_WIDTH beats, LSB chunk first. Define
//            TX_PROTOCOL_MUX_RR_EN for round-robin grants (else fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module tx_protocol_mux #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int TX_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    tx_protocol_mux_if.slave   bus
);
    localparam int NBEATS    = (DATA_WIDTH + TX_WIDTH - 1) / TX_WIDTH;
    localparam int BEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SEL_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PAD_WIDTH = NBEATS * TX_WIDTH;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NBEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_NEXT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PAD_WIDTH-1:0]   r_shift;
    logic [BEAT_BITS-1:0]   r_cnt;
    logic                   r_last;
    logic [SEL_BITS-1:0]    r_cur;
    logic [NUM_CH-1:0]      r_ack;
    logic                   r_tx_rdy;
    logic                   r_busy;

    logic [SEL_BITS-1:0]    w_gnt;
    logic [SEL_BITS-1:0]    w_sel;
    logic                   w_any_req;
    logic                   w_capture;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [PAD_WIDTH-1:0]   w_word_pad;

    assign w_any_req = |bus.src_rdy;

`ifdef TX_PROTOCOL_MUX_RR_EN
    logic [SEL_BITS-1:0] r_ptr;
    logic [SEL_BITS-1:0] w_ptr_next;
    int                  w_idx;

    // Descending scan so the nearest requester after r_ptr overwrites last.
    always_comb begin
        w_gnt = '0;
        w_idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NUM_CH;
            if (bus.src_rdy[w_idx]) begin
                w_gnt = SEL_BITS'(w_idx);
            end
        end
    end

    assign w_ptr_next = SEL_BITS'((int'(w_gnt) + 1) % NUM_CH);
`else
    always_comb begin
        w_gnt = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus.src_rdy[k]) begin
                w_gnt = SEL_BITS'(k);
            end
        end
    end
`endif

    // In IDLE the arbiter picks the source; afterwards only the locked one counts.
    assign w_sel     = (r_state == ST_IDLE) ? w_gnt : r_cur;
    assign w_capture = ((r_state == ST_IDLE) && w_any_req) ||
                       ((r_state == ST_NEXT) && bus.src_rdy[r_cur]);
    assign w_word    = bus.src_data[w_sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_word_pad                   = '0;
        w_word_pad[DATA_WIDTH-1:0]   = w_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_cur    <= '0;
            r_ack    <= '0;
            r_tx_rdy <= 1'b0;
            r_busy   <= 1'b0;
`ifdef TX_PROTOCOL_MUX_RR_EN
            r_ptr    <= '0;
`endif
        end else begin
            r_ack <= '0;
            if (w_capture) begin
                r_shift  <= w_word_pad;
                r_last   <= bus.src_eof[w_sel];
                r_cur    <= w_sel;
                r_cnt    <= '0;
                r_ack    <= NUM_CH'(1) << w_sel;
                r_tx_rdy <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= ST_SEND;
            end else begin
                case (r_state)
                    ST_SEND: begin
                        if (bus.tx_ack) begin
                            if (r_cnt != LAST_BEAT) begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_shift <= r_shift >> TX_WIDTH;
                            end else begin
                                r_tx_rdy <= 1'b0;
                                if (r_last) begin
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_state <= ST_NEXT;
                                end
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (bus.src_eof[r_cur]) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
`ifdef TX_PROTOCOL_MUX_RR_EN
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_ptr <= w_ptr_next;
            end
`endif
        end
    end

    assign bus.src_ack = r_ack;
    assign bus.tx_data = r_shift[TX_WIDTH-1:0];
    assign bus.tx_rdy  = r_tx_rdy;
    assign bus.busy    = r_busy;
    assign bus.cur_src = r_cur;

endmodule
`default_nettype wire
